hyperbus_cfg_shadow_regs: RTL and testbench
===========================================

HYPERBUS_CFG_SHADOW_REGS -- requirements
Module: hyperbus_cfg_shadow_regs

Interface
REQ-001 SHALL have parameter NumRegs, default 17: number of data configuration registers.
REQ-002 SHALL have parameter RegAddrWidth, default 32: width of the register-bus byte address.
REQ-003 SHALL have parameter RegDataWidth, default 32: register width; SHALL be a power of two and >= 32.
REQ-004 SHALL have parameter RstVal, default all zeros, NumRegs x RegDataWidth packed: reset value of each data register.
REQ-005 SHALL have parameter WaitCntWidth, default 16: width of the pending-age counter; SHALL be <= RegDataWidth-16.
REQ-006 SHALL have ports:
- clk_i  in  1  clock; only clock.
- rst_ni  in  1  synchronous active-low reset.
- reg_valid_i  in  1  request valid.
- reg_write_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  RegAddrWidth  byte address.
- reg_wdata_i  in  RegDataWidth  write data.
- reg_wstrb_i  in  RegDataWidth/8  byte strobes.
- reg_ready_o  out  1  request accepted.
- reg_rdata_o  out  RegDataWidth  read data.
- reg_error_o  out  1  unmapped or illegal access.
- trans_active_i  in  1  HyperBus transfer in progress.
- active_regs_o  out  NumRegs*RegDataWidth  committed configuration; register k at bits [k*RegDataWidth +: RegDataWidth].
- pending_o  out  1  shadow differs from active, awaiting commit.
- commit_o  out  1  one-cycle pulse when active is loaded from shadow.

Function
REQ-007 SHALL decode index = reg_addr_i >> log2(RegDataWidth/8):
- 0 = CTRL
- 1 = STATUS
- 2..NumRegs+1 = data register index-2
- others unmapped.
REQ-008 SHALL hold an active copy and a shadow copy of every data register; active_regs_o SHALL always equal the active copy.
REQ-009 SHALL accept a request when reg_valid_i & reg_ready_o; reads SHALL be combinational (rdata valid in the accepting cycle).
REQ-010 SHALL drive reg_error_o=1 for unmapped indices and for writes to STATUS; such writes SHALL change no state.
REQ-011 SHALL apply byte-strobe merging to data writes: new = (old & ~mask) | (wdata & mask), where mask byte i = wstrb[i]; writes SHALL update the shadow only, never the active copy.
REQ-012 SHALL define CTRL as follows:
- bit0 AUTO: read/write, reset 1.
- bit1 COMMIT: write-1 pulse, reads 0.
- bit2 DISCARD: write-1 pulse, reads 0.
- other bits read 0.
REQ-013 SHALL define STATUS (read-only) as:
- bit0 = pending
- bit1 = AUTO
- [16 +: WaitCntWidth] = wait count
- remaining bits 0.
REQ-014 SHALL implement FSM states IDLE, PENDING, COMMIT.
REQ-015 IDLE -> PENDING on any accepted data write, including a write of identical data.
REQ-016 In PENDING, a commit request SHALL be latched when AUTO=1 or COMMIT is written; the request SHALL persist until committed or discarded.
REQ-017 PENDING -> COMMIT when a commit request is present and trans_active_i=0.
REQ-018 A COMMIT write in the same cycle as trans_active_i=0 SHALL transition to COMMIT on the next edge.
REQ-019 COMMIT SHALL last exactly one cycle:
- active <= shadow at its ending edge;
- commit_o=1 during it;
- reg_ready_o=0 during it;
- next state IDLE.
REQ-020 reg_ready_o SHALL be 1 in IDLE and PENDING.
REQ-021 Data writes accepted in PENDING SHALL be accumulated into the shadow and included in the next commit.
REQ-022 A DISCARD write in PENDING SHALL load shadow <= active and return to IDLE, clearing the commit request. If COMMIT and DISCARD are written in the same word, DISCARD SHALL win. DISCARD in IDLE SHALL be a no-op.
REQ-023 pending_o SHALL be 1 in PENDING and COMMIT.
REQ-024 The wait counter SHALL clear on entering PENDING, increment each cycle in PENDING, saturate at all-ones, and hold its value in IDLE.
REQ-025 Reads of CTRL/STATUS during COMMIT are not accepted (ready=0); master SHALL retry.

Reset
REQ-026 On clk_i edge with rst_ni=0, the block SHALL reset to the following state, including mid-COMMIT:
- active = shadow = RstVal
- state = IDLE
- AUTO = 1
- commit request cleared
- wait count = 0
- commit_o = 0
- pending_o = 0
- no partial commit visible.

Configuration
REQ-027 With HYPERBUS_CFG_SHADOW_READBACK_EN defined, data-register reads SHALL return the shadow copy.
REQ-028 Without HYPERBUS_CFG_SHADOW_READBACK_EN, data-register reads SHALL return the active copy; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then read index 2..NumRegs+1 -> RstVal values; STATUS reads 0x2; pending_o=0.
REQ-030 AUTO=1, trans_active_i=0, write 0xDEADBEEF to data reg 0 with wstrb=0x3 -> pending_o=1 for 2 cycles, commit_o pulse once, active reg0 = RstVal[0][31:16] concatenated with 0xBEEF.
REQ-031 trans_active_i=1 for 100 cycles, write data reg 3 -> no commit, STATUS[31:16]=100 near release; on trans_active_i=0, commit occurs within 1 cycle.
REQ-032 AUTO=0, write reg 1 = 0x5, then write CTRL=0x4 (DISCARD) -> pending_o=0, commit_o never pulses, active unchanged; write CTRL=0x6 -> discard wins.
REQ-033 Write address index NumRegs+2 and write STATUS -> reg_error_o=1, no state change; assert rst_ni=0 during COMMIT -> active = RstVal next cycle, commit_o=0.

Source files
------------

// File: rtl/hyperbus_cfg_shadow_regs.sv
// HyperBus configuration shadow registers.
// Register-bus writes go to a shadow copy. The shadow is copied into the active
// copy in one cycle, and only while no HyperBus transfer is in flight.
// Optional: HYPERBUS_CFG_SHADOW_READBACK_EN makes data-register reads return
// the shadow copy instead of the active copy.
module hyperbus_cfg_shadow_regs #(
  parameter int unsigned NumRegs      = 17,
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RegDataWidth = 32,
  parameter logic [NumRegs*RegDataWidth-1:0] RstVal = '0,
  parameter int unsigned WaitCntWidth = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            reg_valid_i,
  input  logic                            reg_write_i,
  input  logic [RegAddrWidth-1:0]         reg_addr_i,
  input  logic [RegDataWidth-1:0]         reg_wdata_i,
  input  logic [RegDataWidth/8-1:0]       reg_wstrb_i,
  output logic                            reg_ready_o,
  output logic [RegDataWidth-1:0]         reg_rdata_o,
  output logic                            reg_error_o,
  input  logic                            trans_active_i,
  output logic [NumRegs*RegDataWidth-1:0] active_regs_o,
  output logic                            pending_o,
  output logic                            commit_o
);

  localparam int unsigned StrbW = RegDataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_e;

  state_e                                 state_q, state_d;
  logic [NumRegs-1:0][RegDataWidth-1:0]   active_q, shadow_q, rd_src;
  logic                                   auto_q, auto_d;
  logic                                   creq_q, creq_d;
  logic [WaitCntWidth-1:0]                wcnt_q, wcnt_d;

  logic [RegAddrWidth-1:0]  idx;
  logic                     is_ctrl, is_status, is_data, bad;
  logic                     acc, wr_ok, data_wr, ctrl_wr, commit_wr, discard_wr, creq_now;
  logic [RegDataWidth-1:0]  wmask, status;

  // Address decode and request qualification
  assign idx        = reg_addr_i >> OffW;
  assign is_ctrl    = (idx == '0);
  assign is_status  = (idx == RegAddrWidth'(1));
  assign is_data    = (idx >= RegAddrWidth'(2)) && (idx < RegAddrWidth'(NumRegs + 2));
  assign bad        = ~(is_ctrl | is_status | is_data) | (is_status & reg_write_i);
  assign acc        = reg_valid_i & reg_ready_o;
  assign wr_ok      = acc & reg_write_i & ~bad;
  assign data_wr    = wr_ok & is_data;
  assign ctrl_wr    = wr_ok & is_ctrl & reg_wstrb_i[0];
  assign commit_wr  = ctrl_wr & reg_wdata_i[1];
  assign discard_wr = ctrl_wr & reg_wdata_i[2];
  assign creq_now   = creq_q | auto_q | commit_wr;
  assign reg_error_o = acc & bad;

`ifdef HYPERBUS_CFG_SHADOW_READBACK_EN
  assign rd_src = shadow_q;
`else
  assign rd_src = active_q;
`endif

  assign active_regs_o = active_q;

  // Byte-strobe expansion to a bit mask
  always_comb begin
    wmask = '0;
    for (int i = 0; i < StrbW; i++) wmask[i*8 +: 8] = {8{reg_wstrb_i[i]}};
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; DISCARD takes priority over any commit request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_wr) state_d = PENDING;
      PENDING: if (discard_wr) state_d = IDLE;
               else if (creq_now && !trans_active_i) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    reg_ready_o = (state_q != COMMIT);
    pending_o   = (state_q != IDLE);
    commit_o    = (state_q == COMMIT);
  end

  // Control next state: AUTO bit, sticky commit request, saturating wait counter
  always_comb begin
    auto_d = ctrl_wr ? reg_wdata_i[0] : auto_q;
    creq_d = (state_q == PENDING && state_d == PENDING) ? creq_now : 1'b0;
    wcnt_d = wcnt_q;
    if (state_q == IDLE && state_d == PENDING) wcnt_d = '0;
    else if (state_q == PENDING && wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      auto_q <= 1'b1;
      creq_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      auto_q <= auto_d;
      creq_q <= creq_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Per-register shadow/active pair
  for (genvar k = 0; k < NumRegs; k++) begin : g_reg
    logic we;
    assign we = data_wr && (idx == RegAddrWidth'(k + 2));

    // Shadow: merged writes, reload from active on discard
    always_ff @(posedge clk_i) begin
      if (!rst_ni)                             shadow_q[k] <= RstVal[k*RegDataWidth +: RegDataWidth];
      else if (state_q == PENDING && discard_wr) shadow_q[k] <= active_q[k];
      else if (we)                             shadow_q[k] <= (shadow_q[k] & ~wmask) | (reg_wdata_i & wmask);
    end

    // Active: loaded from shadow at the end of the COMMIT cycle
    always_ff @(posedge clk_i) begin
      if (!rst_ni)               active_q[k] <= RstVal[k*RegDataWidth +: RegDataWidth];
      else if (state_q == COMMIT) active_q[k] <= shadow_q[k];
    end
  end

  // Read mux and STATUS assembly
  always_comb begin
    status = '0;
    status[0] = pending_o;
    status[1] = auto_q;
    status[16 +: WaitCntWidth] = wcnt_q;
    reg_rdata_o = '0;
    if (is_ctrl)        reg_rdata_o[0] = auto_q;
    else if (is_status) reg_rdata_o = status;
    else begin
      for (int k = 0; k < NumRegs; k++)
        if (idx == RegAddrWidth'(k + 2)) reg_rdata_o = rd_src[k];
    end
  end

endmodule

// File: tb/tb_hyperbus_cfg_shadow_regs.sv
// Directed bench for hyperbus_cfg_shadow_regs, using the default geometry
// (17 x 32-bit registers) and a non-zero reset pattern.
module tb_hyperbus_cfg_shadow_regs;

  localparam int N = 17;

  function automatic logic [31:0] rw(input int k);
    return 32'hA5A5_0000 | 32'(k);
  endfunction

  function automatic logic [N*32-1:0] build_rst();
    logic [N*32-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*32 +: 32] = rw(k);
    return v;
  endfunction

  localparam logic [N*32-1:0] RST = build_rst();

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid, write, trans;
  logic [31:0]   addr, wdata;
  logic [3:0]    wstrb;
  logic          ready, err, pend, commit;
  logic [31:0]   rdata;
  logic [N*32-1:0] active;

  int n_checks = 0;
  int n_err = 0;
  int pend_cyc = 0;
  int commit_cnt = 0;
  int p0, c0;
  logic [31:0] rd;
  logic e;

  hyperbus_cfg_shadow_regs #(.RstVal(RST)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_valid_i(valid), .reg_write_i(write), .reg_addr_i(addr),
    .reg_wdata_i(wdata), .reg_wstrb_i(wstrb),
    .reg_ready_o(ready), .reg_rdata_o(rdata), .reg_error_o(err),
    .trans_active_i(trans), .active_regs_o(active),
    .pending_o(pend), .commit_o(commit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pend)   pend_cyc++;
      if (commit) commit_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic er);
    @(negedge clk);
    valid = 1'b1; write = 1'b1; addr = a; wdata = d; wstrb = s;
    #1 er = err;
    @(posedge clk);
    #1 valid = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic er);
    @(negedge clk);
    valid = 1'b1; write = 1'b0; addr = a;
    #1 d = rdata; er = err;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  function automatic logic [31:0] act(input int k);
    return active[k*32 +: 32];
  endfunction

  initial begin
    rst_n = 1'b0; valid = 1'b0; write = 1'b0; trans = 1'b0;
    addr = '0; wdata = '0; wstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset state
    check("rst_pending", 64'(pend), 64'd0);
    check("rst_commit",  64'(commit), 64'd0);
    check("rst_ready",   64'(ready), 64'd1);
    for (int k = 0; k < N; k++) begin
      bus_read(32'((k + 2) * 4), rd, e);
      check($sformatf("rst_read_reg%0d", k), 64'(rd), 64'(rw(k)));
    end
    bus_read(32'h4, rd, e);
    check("rst_status", 64'(rd), 64'h2);
    check("rst_status_err", 64'(e), 64'd0);
    bus_read(32'h0, rd, e);
    check("rst_ctrl", 64'(rd), 64'h1);

    // AUTO commit with partial strobes
    p0 = pend_cyc; c0 = commit_cnt;
    bus_write(32'h8, 32'hDEADBEEF, 4'h3, e);
    repeat (4) @(posedge clk);
    #1;
    check("auto_pend_cycles", 64'(pend_cyc - p0), 64'd2);
    check("auto_commit_pulses", 64'(commit_cnt - c0), 64'd1);
    check("auto_active0", 64'(act(0)), 64'hA5A5BEEF);
    bus_read(32'h4, rd, e);
    check("auto_status_after", 64'(rd), 64'h0001_0002);

    // Commit held off by an active transfer
    @(negedge clk) trans = 1'b1;
    c0 = commit_cnt;
    bus_write(32'd20, 32'h12345678, 4'hF, e);
    repeat (100) @(posedge clk);
    bus_read(32'h4, rd, e);
    check("hold_status", 64'(rd), 64'h0064_0003);
    check("hold_no_commit", 64'(commit_cnt - c0), 64'd0);
    check("hold_active3", 64'(act(3)), 64'(rw(3)));
    @(negedge clk) trans = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release_commit", 64'(commit), 64'd1);
    @(posedge clk);
    #1;
    check("release_active3", 64'(act(3)), 64'h12345678);
    check("release_pending", 64'(pend), 64'd0);

    // Manual mode: discard
    bus_write(32'h0, 32'h0, 4'hF, e);
    c0 = commit_cnt;
    bus_write(32'd12, 32'h5, 4'hF, e);
    repeat (3) @(posedge clk);
    #1;
    check("man_pending", 64'(pend), 64'd1);
    bus_read(32'd12, rd, e);
`ifdef HYPERBUS_CFG_SHADOW_READBACK_EN
    check("man_readback", 64'(rd), 64'h5);
`else
    check("man_readback", 64'(rd), 64'(rw(1)));
`endif
    bus_write(32'h0, 32'h4, 4'hF, e);
    check("discard_pending", 64'(pend), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("discard_no_commit", 64'(commit_cnt - c0), 64'd0);
    check("discard_active1", 64'(act(1)), 64'(rw(1)));
    bus_read(32'h0, rd, e);
    check("ctrl_auto_off", 64'(rd), 64'h0);
    bus_write(32'd12, 32'h7, 4'hF, e);
    bus_write(32'h0, 32'h6, 4'hF, e);
    check("discard_wins_pending", 64'(pend), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("discard_wins_no_commit", 64'(commit_cnt - c0), 64'd0);
    check("discard_wins_active1", 64'(act(1)), 64'(rw(1)));

    // Zero-strobe write still pends; explicit COMMIT proves shadow was restored
    bus_write(32'd12, 32'hFFFFFFFF, 4'h0, e);
    check("zero_strb_pending", 64'(pend), 64'd1);
    bus_write(32'h0, 32'h2, 4'hF, e);
    check("commit_wr_next_edge", 64'(commit), 64'd1);
    @(posedge clk);
    #1;
    check("restored_active1", 64'(act(1)), 64'(rw(1)));
    bus_write(32'd12, 32'hCAFEF00D, 4'hA, e);
    bus_write(32'h0, 32'h2, 4'hF, e);
    @(posedge clk);
    #1;
    check("merge_active1", 64'(act(1)), 64'hCAA5F001);

    // Illegal accesses
    bus_write(32'(($unsigned(N) + 2) * 4), 32'hFFFFFFFF, 4'hF, e);
    check("unmapped_wr_err", 64'(e), 64'd1);
    check("unmapped_wr_pend", 64'(pend), 64'd0);
    bus_write(32'h4, 32'hFFFFFFFF, 4'hF, e);
    check("status_wr_err", 64'(e), 64'd1);
    bus_read(32'h4, rd, e);
    check("status_unchanged", 64'(rd), 64'h0001_0000);
    check("status_rd_err", 64'(e), 64'd0);
    bus_read(32'h1000, rd, e);
    check("unmapped_rd_err", 64'(e), 64'd1);

    // Reset in the middle of COMMIT
    bus_write(32'h0, 32'h1, 4'hF, e);
    bus_write(32'h8, 32'h11111111, 4'hF, e);
    @(posedge clk);
    #1;
    check("pre_rst_commit", 64'(commit), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_active0", 64'(act(0)), 64'(rw(0)));
    check("midrst_commit", 64'(commit), 64'd0);
    check("midrst_pending", 64'(pend), 64'd0);
    rst_n = 1'b1;
    bus_read(32'h4, rd, e);
    check("midrst_status", 64'(rd), 64'h2);
    bus_read(32'h8, rd, e);
    check("midrst_read0", 64'(rd), 64'(rw(0)));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
